// File: rtl/sng_pkg.sv
// Shared types and helpers for the stochastic number generator.
//   sng_state_e  : control FSM state (SNG_IDLE, SNG_RUN)
//   SNG_*        : default and fixed widths
//   sng_saturate : clamp a probability numerator to 2^data_w
package sng_pkg;

    localparam int unsigned SNG_RND_W     = 32;
    localparam int unsigned SNG_DATA_W    = 8;
    localparam int unsigned SNG_LEN_W     = 10;
    // Widest probability value the saturate helper handles (DATA_W <= 32).
    localparam int unsigned SNG_VAL_MAX_W = SNG_RND_W + 1;

    typedef enum logic {
        SNG_IDLE = 1'b0,
        SNG_RUN  = 1'b1
    } sng_state_e;

    // Values above 2^data_w mean "always 1", so they are clamped to exactly 2^data_w.
    function automatic logic [SNG_VAL_MAX_W-1:0] sng_saturate(
        input logic [SNG_VAL_MAX_W-1:0] value,
        input int unsigned              data_w
    );
        logic [SNG_VAL_MAX_W-1:0] limit;
        limit = SNG_VAL_MAX_W'(1) << data_w;
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/sng_cmp.sv
// Slice select and compare for the SNG.
//   rnd    in   32        free-running random word
//   value  in   DATA_W+1  probability numerator (already saturated)
//   hit_c  out  1         combinational: rnd[RND_LSB +: DATA_W] < value
module sng_cmp
    import sng_pkg::*;
#(
    parameter int unsigned DATA_W  = SNG_DATA_W,
    parameter int unsigned RND_LSB = 0
) (
    input  logic [SNG_RND_W-1:0] rnd,
    input  logic [DATA_W:0]      value,
    output logic                 hit_c
);

    localparam int unsigned VAL_W = DATA_W + 1;

    logic [DATA_W-1:0] slice_c;
    logic              rnd_unused_c;

    // The slice is one bit narrower than value, so value = 2^DATA_W always hits.
    always_comb begin
        slice_c = rnd[RND_LSB +: DATA_W];
        hit_c   = VAL_W'(slice_c) < value;
    end

    // Bits outside the slice are intentionally ignored.
    assign rnd_unused_c = ^rnd;

endmodule

// File: rtl/sng_stream_gen.sv
// Stochastic number generator: turns a probability value into a Bernoulli
// bitstream of programmable length over a valid/ready stream and reports the
// ones-count when the stream completes.
//   clk, rst        clock, synchronous active-high reset
//   rnd             free-running random word (never stalled)
//   in_valid/ready  request handshake carrying in_value and in_len
//   in_value        probability numerator over 2^DATA_W (saturates)
//   in_len          stream length minus one
//   abort           drop the current stream without a done pulse
//   bit_valid/ready output bit handshake carrying bit_out and bit_last
//   done            one-cycle pulse after the last bit is accepted
//   ones_count      ones in the last finished stream, held until next done
module sng_stream_gen
    import sng_pkg::*;
#(
    parameter int unsigned DATA_W  = SNG_DATA_W,
    parameter int unsigned LEN_W   = SNG_LEN_W,
    parameter int unsigned RND_LSB = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SNG_RND_W-1:0] rnd,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W:0]      in_value,
    input  logic [LEN_W-1:0]     in_len,
    input  logic                 abort,
    output logic                 bit_valid,
    input  logic                 bit_ready,
    output logic                 bit_out,
    output logic                 bit_last,
    output logic                 done,
    output logic [LEN_W:0]       ones_count
);

    localparam int unsigned CNT_W = LEN_W + 1;
    localparam int unsigned VAL_W = DATA_W + 1;

    sng_state_e       state;
    sng_state_e       state_nxt;
    logic [VAL_W-1:0] value_q;
    logic [LEN_W-1:0] len_q;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] acc;

    logic hit_c;
    logic run_c;
    logic take_c;
    logic accept_c;
    logic last_accept_c;
    logic load_c;
    logic more_c;

    sng_cmp #(
        .DATA_W  (DATA_W),
        .RND_LSB (RND_LSB)
    ) u_cmp (
        .rnd   (rnd),
        .value (value_q),
        .hit_c (hit_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SNG_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: abort and last-bit acceptance both end a stream.
    always_comb begin
        state_nxt = state;
        case (state)
            SNG_IDLE: if (in_valid)                 state_nxt = SNG_RUN;
            SNG_RUN:  if (abort || last_accept_c)   state_nxt = SNG_IDLE;
            default:                                state_nxt = SNG_IDLE;
        endcase
    end

    // Decoded controls from the current state and handshakes.
    always_comb begin
        in_ready      = 1'b0;
        run_c         = 1'b0;
        take_c        = 1'b0;
        accept_c      = 1'b0;
        last_accept_c = 1'b0;
        load_c        = 1'b0;
        more_c        = 1'b0;

        in_ready      = (state == SNG_IDLE);
        run_c         = (state == SNG_RUN);
        take_c        = in_ready & in_valid;
        accept_c      = run_c & bit_valid & bit_ready;
        last_accept_c = accept_c & bit_last;
        // Output register refills when empty or being drained; rnd during a stall is dropped.
        load_c        = run_c & ~abort & (~bit_valid | bit_ready);
        more_c        = (idx <= CNT_W'(len_q));
    end

    // Request latch, counters, output bit register and completion report.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q    <= '0;
            len_q      <= '0;
            idx        <= '0;
            acc        <= '0;
            bit_valid  <= 1'b0;
            bit_out    <= 1'b0;
            bit_last   <= 1'b0;
            done       <= 1'b0;
            ones_count <= '0;
        end else begin
            done <= 1'b0;

            if (take_c) begin
                value_q <= VAL_W'(sng_saturate(SNG_VAL_MAX_W'(in_value), DATA_W));
                len_q   <= in_len;
                idx     <= '0;
                acc     <= '0;
            end

            if (accept_c) begin
                acc <= acc + CNT_W'(bit_out);
            end

            if (run_c && abort) begin
                bit_valid <= 1'b0;
                bit_last  <= 1'b0;
            end else if (load_c) begin
                if (more_c) begin
                    bit_valid <= 1'b1;
                    bit_out   <= hit_c;
                    bit_last  <= (idx == CNT_W'(len_q));
                    idx       <= idx + CNT_W'(1);
                end else begin
                    bit_valid <= 1'b0;
                    bit_last  <= 1'b0;
                end
            end

            // Abort on the same cycle as the last handshake suppresses completion.
            if (last_accept_c && !abort) begin
                done       <= 1'b1;
                ones_count <= acc + CNT_W'(bit_out);
            end
        end
    end

endmodule

// File: tb/tb_sng_stream_gen.sv
// Directed bench for sng_stream_gen (DATA_W=8, LEN_W=10, RND_LSB=0).
module tb_sng_stream_gen;

    logic        clk;
    logic        rst;
    logic [31:0] rnd;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  in_value;
    logic [9:0]  in_len;
    logic        abort;
    logic        bit_valid;
    logic        bit_ready;
    logic        bit_out;
    logic        bit_last;
    logic        done;
    logic [10:0] ones_count;

    int n_assert = 0;
    int n_fail   = 0;

    sng_stream_gen #(
        .DATA_W  (8),
        .LEN_W   (10),
        .RND_LSB (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rnd        (rnd),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_value   (in_value),
        .in_len     (in_len),
        .abort      (abort),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .bit_out    (bit_out),
        .bit_last   (bit_last),
        .done       (done),
        .ones_count (ones_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] xs32(input logic [31:0] x);
        logic [31:0] y;
        y = x;
        y = y ^ (y << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk(tag, {26'd0, in_ready, bit_valid, bit_out, bit_last, done, 1'b0}, 32'h20);
        chk({tag, "_ones"}, 32'(ones_count), 32'd0);
    endtask

    // Issue one request; returns in the cycle right after the handshake edge.
    task automatic req(input int val, input int len);
        in_valid = 1'b1;
        in_value = 9'(val);
        in_len   = 10'(len);
        chk("req_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Full stream with rnd ramping 0,1,2,...; bit k is 1 iff k < min(val,256).
    task automatic stream(input string tag, input int val, input int len, input int exp_ones);
        int lim;
        lim = (val > 256) ? 256 : val;
        req(val, len);
        for (int k = 0; k <= len; k++) begin
            rnd = 32'(k);
            tick();
            chk({tag, "_bit"}, {29'd0, bit_valid, bit_out, bit_last},
                {29'd0, 1'b1, 1'(k < lim), 1'(k == len)});
        end
        rnd = 32'd0;
        tick();
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_ones"}, 32'(ones_count), 32'(exp_ones));
        chk({tag, "_idle"}, {30'd0, bit_valid, in_ready}, 32'd1);
        tick();
        chk({tag, "_pulse"}, 32'(done), 32'd0);
        chk({tag, "_hold"}, 32'(ones_count), 32'(exp_ones));
    endtask

    // Two-bit stream with rnd from xorshift32 seeded at 0xDEADBEEF in the request cycle.
    task automatic xs_stream(input string tag, input int val, input logic b0, input logic b1,
                             input int exp_ones);
        rnd = 32'hDEADBEEF;
        req(val, 1);
        rnd = xs32(rnd);
        tick();
        chk({tag, "_b0"}, {29'd0, bit_valid, bit_out, bit_last}, {29'd0, 1'b1, b0, 1'b0});
        rnd = xs32(rnd);
        tick();
        chk({tag, "_b1"}, {29'd0, bit_valid, bit_out, bit_last}, {29'd0, 1'b1, b1, 1'b1});
        rnd = xs32(rnd);
        tick();
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_ones"}, 32'(ones_count), 32'(exp_ones));
    endtask

    initial begin
        rst       = 1'b1;
        rnd       = 32'd0;
        in_valid  = 1'b0;
        in_value  = 9'd0;
        in_len    = 10'd0;
        abort     = 1'b0;
        bit_ready = 1'b1;

        tick();
        tick();
        chk_reset_vals("reset");
        rst = 1'b0;
        tick();

        // 1: half probability over a full ramp of 256 slices.
        stream("t1", 128, 255, 128);

        // 2: probability extremes, including a saturating value.
        stream("t2_zero", 0, 15, 0);
        stream("t2_full", 256, 15, 16);
        stream("t2_sat", 300, 15, 16);

        // 3: backpressure on bit 2; rnd=200 during the stall must not be sampled.
        req(128, 7);
        rnd = 32'd0;   tick(); chk("t3_b0", {29'd0, bit_valid, bit_out, bit_last}, 32'd6);
        rnd = 32'd40;  tick(); chk("t3_b1", {29'd0, bit_valid, bit_out, bit_last}, 32'd6);
        rnd = 32'd80;  tick(); chk("t3_b2", {29'd0, bit_valid, bit_out, bit_last}, 32'd6);
        bit_ready = 1'b0;
        rnd = 32'd200;
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("t3_stall", {29'd0, bit_valid, bit_out, bit_last}, 32'd6);
            chk("t3_stall_done", 32'(done), 32'd0);
        end
        bit_ready = 1'b1;
        rnd = 32'd120; tick(); chk("t3_b3", {29'd0, bit_valid, bit_out, bit_last}, 32'd6);
        rnd = 32'd160; tick(); chk("t3_b4", {29'd0, bit_valid, bit_out, bit_last}, 32'd4);
        rnd = 32'd200; tick(); chk("t3_b5", {29'd0, bit_valid, bit_out, bit_last}, 32'd4);
        rnd = 32'd240; tick(); chk("t3_b6", {29'd0, bit_valid, bit_out, bit_last}, 32'd4);
        rnd = 32'd130; tick(); chk("t3_b7", {29'd0, bit_valid, bit_out, bit_last}, 32'd5);
        rnd = 32'd0;   tick();
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_ones", 32'(ones_count), 32'd4);
        tick();
        chk("t3_pulse", 32'(done), 32'd0);

        // 4a: abort at bit 4 of a 16-bit all-ones stream.
        req(256, 15);
        for (int k = 0; k < 5; k++) begin
            rnd = 32'(k);
            tick();
        end
        chk("t4_b4", {29'd0, bit_valid, bit_out, bit_last}, 32'd6);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_abort", {29'd0, bit_valid, done, in_ready}, 32'd1);
        chk("t4_ones", 32'(ones_count), 32'd4);
        tick();
        chk("t4_nodone", {30'd0, bit_valid, done}, 32'd0);

        // 4b: abort coincident with the last-bit handshake.
        req(256, 1);
        rnd = 32'd0; tick();
        rnd = 32'd0; tick();
        chk("t4b_last", {29'd0, bit_valid, bit_out, bit_last}, 32'd7);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4b_abort", {29'd0, bit_valid, done, in_ready}, 32'd1);
        chk("t4b_ones", 32'(ones_count), 32'd4);
        tick();
        chk("t4b_nodone", 32'(done), 32'd0);

        // 4c: abort while idle does not block a request.
        abort    = 1'b1;
        in_valid = 1'b1;
        in_value = 9'd256;
        in_len   = 10'd1;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("t4c_run", 32'(in_ready), 32'd0);
        rnd = 32'd9; tick(); chk("t4c_b0", {29'd0, bit_valid, bit_out, bit_last}, 32'd6);
        rnd = 32'd9; tick(); chk("t4c_b1", {29'd0, bit_valid, bit_out, bit_last}, 32'd7);
        tick();
        chk("t4c_done", 32'(done), 32'd1);
        chk("t4c_ones", 32'(ones_count), 32'd2);

        // 5: synchronous reset mid-stream, then a clean stream from bit 0.
        req(256, 15);
        rnd = 32'd0; tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk_reset_vals("t5_reset");
        rst = 1'b0;
        stream("t5_after", 2, 3, 2);

        // 6: xorshift32 slices 183 then 66.
        xs_stream("t6_200", 200, 1'b1, 1'b1, 2);
        xs_stream("t6_100", 100, 1'b0, 1'b1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
